time_counter: RTL

TIME_COUNTER -- requirements
Module: time_counter

---
 rtl/time_counter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/time_counter.sv
// Stopwatch / countdown timer with a 4-digit BCD display (SS.cc).
// The prescaler produces a tick every TICK_DIV run cycles; count steps up or down on each tick.
module time_counter #(
    parameter int TICK_DIV = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  current_state,
    input  logic [15:0] timeout,
    input  logic [1:0]  cnt,
    input  logic        clr,
    output logic [15:0] count,
    output logic        done,
    output logic        done_pulse,
    output logic [3:0]  edit_mask,
    output logic        tick
);

    typedef enum logic [1:0] {
        UP_WAIT   = 2'b00,
        UP_RUN    = 2'b01,
        DOWN_WAIT = 2'b10,
        DOWN_RUN  = 2'b11
    } state_e;

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    state_e          st;
    state_e          prev_q, prev_d;
    logic [PW-1:0]   presc_q, presc_d, presc_eff;
    logic [15:0]     count_q, count_d, dec_val;
    logic            done_q, done_d;
    logic            pulse_q, pulse_d;
    logic            tick_q, tick_d;
    logic [3:0]      mask_q, mask_d;
    logic            run, was_down, at_wrap;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] bcd_dec(input logic [15:0] v);
        logic [15:0] r;
        logic        borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (borrow) begin
                if (r[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] sanitize(input logic [15:0] v);
        logic [15:0] r;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = (v[4*i +: 4] > 4'd9) ? 4'd9 : v[4*i +: 4];
        end
        return r;
    endfunction

    assign st       = state_e'(current_state);
    assign run      = (st == UP_RUN) || (st == DOWN_RUN);
    assign was_down = (prev_q == DOWN_WAIT) || (prev_q == DOWN_RUN);
    // A fresh state restarts the prescaler so the first tick lands TICK_DIV cycles in.
    assign presc_eff = (st != prev_q) ? '0 : presc_q;
    assign at_wrap   = run && (presc_eff == PRESC_LAST);
    assign dec_val   = bcd_dec(count_q);

    always_comb begin
        prev_d  = st;
        count_d = count_q;
        done_d  = done_q && (st == DOWN_RUN);
        pulse_d = 1'b0;
        tick_d  = 1'b0;
        presc_d = '0;
        mask_d  = (st == DOWN_WAIT) ? (4'b1000 >> cnt) : 4'b0000;
        case (st)
            UP_WAIT: begin
                if (clr || was_down) count_d = '0;
            end
            UP_RUN: begin
                presc_d = at_wrap ? '0 : presc_eff + 1'b1;
                if (clr) begin
                    count_d = '0;
                    presc_d = '0;
                end else if (was_down) begin
                    count_d = '0;
                end else if (at_wrap) begin
                    tick_d  = 1'b1;
                    count_d = bcd_inc(count_q);
                end
            end
            DOWN_WAIT: begin
                count_d = sanitize(timeout);
            end
            DOWN_RUN: begin
                presc_d = at_wrap ? '0 : presc_eff + 1'b1;
                if (clr) begin
                    count_d = '0;
                    presc_d = '0;
                    done_d  = 1'b0;
                end else if (at_wrap) begin
                    tick_d = 1'b1;
                    if (count_q != 16'h0000) begin
                        count_d = dec_val;
                        if (dec_val == 16'h0000) begin
                            done_d  = 1'b1;
                            pulse_d = 1'b1;
                        end
                    end else if (!done_q) begin
                        done_d  = 1'b1;
                        pulse_d = 1'b1;
                    end
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_q  <= UP_WAIT;
            presc_q <= '0;
            count_q <= '0;
            done_q  <= 1'b0;
            pulse_q <= 1'b0;
            tick_q  <= 1'b0;
            mask_q  <= 4'b0000;
        end else begin
            prev_q  <= prev_d;
            presc_q <= presc_d;
            count_q <= count_d;
            done_q  <= done_d;
            pulse_q <= pulse_d;
            tick_q  <= tick_d;
            mask_q  <= mask_d;
        end
    end

    assign count      = count_q;
    assign done       = done_q;
    assign done_pulse = pulse_q;
    assign edit_mask  = mask_q;
    assign tick       = tick_q;

endmodule
